// File: rtl/wb_rr_arbiter_if.sv
// wb_rr_arbiter_if
//   Bus bundle between NM Wishbone classic masters, the round-robin arbiter
//   and the single shared slave.
//   Master-side signals are flat vectors; master k sits at
//   sel[4k+3:4k], adr/dat[32k+31:32k].
//   Modports:
//     slave  - the arbiter's view. It is the slave seen by the masters.
//              It takes m_*_i and s_dat_i/s_ack_i, and drives m_*_o and s_*_o.
//     master - the environment's view (masters plus slave model), with the
//              directions reversed.
interface wb_rr_arbiter_if #(
    parameter int NM = 4
);
    logic [NM-1:0]    m_cyc_i;
    logic [NM-1:0]    m_stb_i;
    logic [NM-1:0]    m_we_i;
    logic [4*NM-1:0]  m_sel_i;
    logic [32*NM-1:0] m_adr_i;
    logic [32*NM-1:0] m_dat_i;
    logic [31:0]      m_dat_o;
    logic [NM-1:0]    m_ack_o;
    logic [NM-1:0]    m_err_o;
    logic             s_cyc_o;
    logic             s_stb_o;
    logic             s_we_o;
    logic [3:0]       s_sel_o;
    logic [31:0]      s_adr_o;
    logic [31:0]      s_dat_o;
    logic [31:0]      s_dat_i;
    logic             s_ack_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
        output m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o,
               s_adr_o, s_dat_o
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, s_dat_i, s_ack_i,
        input  m_dat_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o, s_sel_o,
               s_adr_o, s_dat_o
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
//   Round-robin arbiter that shares one Wishbone classic slave between NM
//   masters.
//   Ownership is granted per CYC-framed transaction. The owner keeps the bus
//   for as many STB/ACK beats as it likes while its CYC stays high.
//   The owner's request is muxed onto the slave. ACK is routed back to the
//   owner only. Read data is broadcast to all masters.
//   Ports:
//     wb_clk_i  clock
//     wb_rst_i  synchronous reset, active-high
//     bus       wb_rr_arbiter_if.slave (m_* master side, s_* slave side)
//   Parameters:
//     NM        number of masters (2..8)
//     TIMEOUT   number of stalled STB cycles before ERR
//               (used only with WB_ARB_TIMEOUT_EN)
//   Build option:
//     WB_ARB_TIMEOUT_EN  adds a stall watchdog that pulses m_err_o[owner].
//                        Without it, m_err_o is constant 0.
module wb_rr_arbiter #(
    parameter int NM      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    wb_rr_arbiter_if.slave bus
);
    localparam int OW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] last_q,  last_d;

    // Packed per-master views, so the owner mux is a plain index.
    logic [NM-1:0][3:0]  sel_v;
    logic [NM-1:0][31:0] adr_v;
    logic [NM-1:0][31:0] dat_v;
    assign sel_v = bus.m_sel_i;
    assign adr_v = bus.m_adr_i;
    assign dat_v = bus.m_dat_i;

    logic own_cyc, own_stb, bus_act, err_fire, found;
    logic [OW-1:0] cand;

    // The bus is live only while the registered owner still holds CYC.
    // Dropping CYC releases the slave in that same cycle.
    always_comb begin
        own_cyc = bus.m_cyc_i[owner_q];
        own_stb = bus.m_stb_i[owner_q];
        bus_act = (state_q == BUSY) && own_cyc;
    end

    // Arbitration and ownership.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        found   = 1'b0;
        cand    = '0;
        case (state_q)
            IDLE: begin
                // Search last+1, last+2, ... so the previous owner comes last.
                for (int i = 1; i <= NM; i++) begin
                    cand = OW'((int'(last_q) + i) % NM);
                    if (!found && bus.m_cyc_i[cand]) begin
                        found   = 1'b1;
                        owner_d = cand;
                    end
                end
                if (found) state_d = BUSY;
            end
            BUSY: begin
                // The release cycle never re-grants.
                // One IDLE cycle always separates two ownerships.
                if (!own_cyc) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_q, tmo_d;

    // Counts owner STB cycles without ACK.
    // ACK or STB low clears it, so ACK always beats ERR.
    // The ERR cycle itself clears the count.
    always_comb begin
        err_fire = 1'b0;
        tmo_d    = '0;
        if (bus_act && own_stb && !bus.s_ack_i) begin
            if (tmo_q == TMO_LAST) err_fire = 1'b1;
            else                   tmo_d    = tmo_q + 8'd1;
        end
    end
`else
    assign err_fire = 1'b0;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NM - 1);
`ifdef WB_ARB_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    // Slave-side mux and master-side return path.
    // Everything toward the slave is zero unless the bus is live.
    always_comb begin
        bus.s_cyc_o = bus_act;
        bus.s_stb_o = bus_act && own_stb && !err_fire;
        bus.s_we_o  = bus_act && bus.m_we_i[owner_q];
        bus.s_sel_o = bus_act ? sel_v[owner_q] : 4'h0;
        bus.s_adr_o = bus_act ? adr_v[owner_q] : 32'h0;
        bus.s_dat_o = bus_act ? dat_v[owner_q] : 32'h0;
        bus.m_dat_o = bus.s_dat_i;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        if (bus_act && bus.s_ack_i) bus.m_ack_o[owner_q] = 1'b1;
        if (err_fire)               bus.m_err_o[owner_q] = 1'b1;
    end
endmodule
